// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for ram_arbiter: size codes, FSM encodings, IO region decode.
package ram_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // UART/IO window: byte address bits [IO_HI:IO_LO] equal to IO_REGION
  localparam logic [1:0]  IO_REGION = 2'b11;
  localparam int unsigned IO_HI     = 17;
  localparam int unsigned IO_LO     = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_TAIL = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Latched per-transaction attributes of the granted request
  typedef struct packed {
    logic        we;
    logic [1:0]  last;   // index of the final byte (n-1)
    logic [31:0] wdata;
  } xfer_t;

  // Index of the last byte for a size code; 10 and 11 both mean a word
  function automatic logic [1:0] last_byte(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 2'd0;
      SZ_H:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection for ram_arbiter. RAM_ARB_RR_EN defined: round-robin starting
// after the last granted channel; undefined: fixed priority, lowest index wins.
module ram_arb_pick #(
  parameter int unsigned NCH = 2,
  parameter int unsigned IW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [NCH-1:0] onehot,
  output logic [IW-1:0]  idx
);

`ifdef RAM_ARB_RR_EN
  // Search from last+1 around the ring; first active request wins
  always_comb begin
    logic [IW-1:0] c;
    onehot = '0;
    idx    = '0;
    c      = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      c = IW'((32'(last) + i) % NCH);
      if (onehot == '0 && req[c]) begin
        onehot[c] = 1'b1;
        idx       = c;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  // Lowest-index active request wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (onehot == '0 && req[i]) begin
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Serialises NCH 1/2/4-byte load/store requests onto a byte-wide RAM/IO bus.
// Arbitration policy selected by macro RAM_ARB_RR_EN (round-robin when defined,
// fixed priority otherwise). RAM read data (mem_din) arrives one cycle after
// its address.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        we,
  input  logic [NCH*ADDR_W-1:0] addr,
  input  logic [NCH*32-1:0]     wdata,
  input  logic [NCH*2-1:0]      size,
  output logic [NCH-1:0]        grant,
  output logic [NCH-1:0]        done,
  output logic [31:0]           rdata,
  output logic [7:0]            mem_dout,
  output logic [ADDR_W-1:0]     mem_a,
  output logic                  mem_wr
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d, k_inc;
  logic [ADDR_W-1:0] base_q, base_d;
  xfer_t             xfer_q, xfer_d;
  logic [NCH-1:0]    grant_d, done_d;
  logic [31:0]       rdata_d;
  logic [ADDR_W-1:0] mem_a_d;
  logic [7:0]        mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic [NCH-1:0]    pick_oh;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     last_q;

  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [1:0]        w_size;
  logic [31:0]       w_wdata;

  logic              stall_c;
  logic              rdy_prev_q;
  logic [7:0]        skid_q;
  logic [7:0]        data_c;

  ram_arb_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req    (req),
    .last   (last_q),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

`ifdef RAM_ARB_RR_EN
  // Last-granted pointer; reset so channel 0 is searched first
  always_ff @(posedge clk) begin
    if (rst)
      last_q <= IW'(NCH - 1);
    else if (rdy && state_q == ST_IDLE && |req)
      last_q <= pick_idx;
  end
`else
  logic unused_idx;
  assign last_q     = '0;
  assign unused_idx = ^pick_idx;
`endif

  // Mux out the winning channel's request fields
  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_size  = '0;
    w_wdata = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (pick_oh[i]) begin
        w_addr  = addr[i*ADDR_W +: ADDR_W];
        w_we    = we[i];
        w_size  = size[i*2 +: 2];
        w_wdata = wdata[i*32 +: 32];
      end
    end
  end

  // UART write stall and bus write strobe; both act in the current cycle
  assign stall_c = (state_q == ST_WRITE) && io_buffer_full &&
                   (mem_a[IO_HI:IO_LO] == IO_REGION);
  assign mem_wr  = mem_wr_q && rdy && !stall_c;

  // Read data belongs to the previous cycle's address; if that cycle was
  // frozen, replay the byte that arrived right after the last live cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_prev_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      rdy_prev_q <= rdy;
      if (rdy_prev_q) skid_q <= mem_din;
    end
  end
  assign data_c = rdy_prev_q ? mem_din : skid_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst)      state_q <= ST_IDLE;
    else if (rdy) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (|req) state_d = w_we ? ST_WRITE : ST_READ;
      ST_WRITE:     if (!stall_c && k_q == xfer_q.last) state_d = ST_DONE;
      ST_READ:      if (k_q == xfer_q.last) state_d = ST_READ_TAIL;
      ST_READ_TAIL: state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs
  always_comb begin
    k_d        = k_q;
    base_d     = base_q;
    xfer_d     = xfer_q;
    grant_d    = grant;
    done_d     = '0;
    rdata_d    = rdata;
    mem_a_d    = mem_a;
    mem_dout_d = mem_dout;
    mem_wr_d   = mem_wr_q;
    k_inc      = k_q + 2'd1;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d     = pick_oh;
          base_d      = w_addr;
          xfer_d.we   = w_we;
          xfer_d.last = last_byte(w_size);
          xfer_d.wdata = w_wdata;
          k_d         = '0;
          rdata_d     = '0;
          mem_a_d     = w_addr;
          mem_dout_d  = w_we ? w_wdata[7:0] : 8'h00;
          mem_wr_d    = w_we;
        end
      end
      ST_WRITE: begin
        if (!stall_c) begin
          if (k_q == xfer_q.last) begin
            mem_wr_d = 1'b0;
            done_d   = grant;
          end else begin
            k_d        = k_inc;
            mem_a_d    = base_q + ADDR_W'(k_inc);
            mem_dout_d = xfer_q.wdata[{k_inc, 3'b000} +: 8];
          end
        end
      end
      ST_READ: begin
        if (k_q != 2'd0) rdata_d[{k_q - 2'd1, 3'b000} +: 8] = data_c;
        if (k_q != xfer_q.last) begin
          k_d     = k_inc;
          mem_a_d = base_q + ADDR_W'(k_inc);
        end
      end
      ST_READ_TAIL: begin
        rdata_d[{k_q, 3'b000} +: 8] = data_c;
        done_d = grant;
      end
      ST_DONE: grant_d = '0;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      base_q   <= '0;
      xfer_q   <= '0;
      grant    <= '0;
      done     <= '0;
      rdata    <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr_q <= 1'b0;
    end else if (rdy) begin
      k_q      <= k_d;
      base_q   <= base_d;
      xfer_q   <= xfer_d;
      grant    <= grant_d;
      done     <= done_d;
      rdata    <= rdata_d;
      mem_a    <= mem_a_d;
      mem_dout <= mem_dout_d;
      mem_wr_q <= mem_wr_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a byte RAM model.
module tb_ram_arbiter;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 32;

`ifdef RAM_ARB_RR_EN
  localparam logic [1:0] G2 = 2'b10;
`else
  localparam logic [1:0] G2 = 2'b01;
`endif

  logic            clk = 1'b0;
  logic            rst, rdy, io_buffer_full;
  logic [7:0]      mem_din;
  logic [NCH-1:0]  req, we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*32-1:0] wdata;
  logic [NCH*2-1:0]  size;
  logic [NCH-1:0]  grant, done;
  logic [31:0]     rdata;
  logic [7:0]      mem_dout;
  logic [AW-1:0]   mem_a;
  logic            mem_wr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_g [3];

  always #5 clk = ~clk;

  ram_arbiter #(.NCH(NCH), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .req            (req),
    .we             (we),
    .addr           (addr),
    .wdata          (wdata),
    .size           (size),
    .grant          (grant),
    .done           (done),
    .rdata          (rdata),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  // Byte RAM, 18-bit decode, synchronous read
  bit [7:0] ram     [0:262143];
  bit       wr_seen [0:262143];

  function automatic logic [7:0] init_byte(input logic [17:0] a);
    case (a)
      18'h00100: return 8'h11;
      18'h00101: return 8'h22;
      18'h00102: return 8'h33;
      18'h00103: return 8'h44;
      18'h02002: return 8'h5A;
      18'h1FFFF: return 8'hA5;
      18'h3FFFF: return 8'h77;
      18'h00000: return 8'h88;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] peek(input logic [17:0] a);
    return wr_seen[a] ? ram[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    mem_din <= peek(mem_a[17:0]);
    if (mem_wr) begin
      ram[mem_a[17:0]]     <= mem_dout;
      wr_seen[mem_a[17:0]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_ch(input int ch, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d);
    we[ch]               = w;
    addr[ch*AW +: AW]    = a;
    size[ch*2 +: 2]      = s;
    wdata[ch*32 +: 32]   = d;
    req[ch]              = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; size = '0;
    exp_g[0] = 2'b01; exp_g[1] = G2; exp_g[2] = 2'b01;

    // Reset state
    cyc(); cyc(); settle();
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_dout", 32'(mem_dout), 32'h0);
    chk("rst mem_wr", 32'(mem_wr), 32'h0);
    cyc(); rst = 1'b0;

    // Single 4-byte read on ch0 @0x100
    cyc(); set_ch(0, 1'b0, 32'h100, 2'b10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      chk("rd4 mem_a", mem_a, 32'h100 + 32'(i));
      chk("rd4 mem_wr", 32'(mem_wr), 32'h0);
    end
    chk("rd4 grant", 32'(grant), 32'h1);
    cyc(); settle();
    chk("rd4 early done", 32'(done), 32'h0);
    cyc(); settle();
    chk("rd4 done", 32'(done), 32'h1);
    chk("rd4 rdata", rdata, 32'h44332211);
    req[0] = 1'b0;

    // Half-word write on ch1; io_buffer_full high but address outside IO window
    cyc(); set_ch(1, 1'b1, 32'h2000, 2'b01, 32'hCAFEBEEF); io_buffer_full = 1'b1;
    cyc(); settle();
    chk("wr2 grant", 32'(grant), 32'h2);
    chk("wr2 b0 mem_wr", 32'(mem_wr), 32'h1);
    chk("wr2 b0 mem_a", mem_a, 32'h2000);
    chk("wr2 b0 dout", 32'(mem_dout), 32'hEF);
    cyc(); settle();
    chk("wr2 b1 mem_wr", 32'(mem_wr), 32'h1);
    chk("wr2 b1 mem_a", mem_a, 32'h2001);
    chk("wr2 b1 dout", 32'(mem_dout), 32'hBE);
    cyc(); settle();
    chk("wr2 done", 32'(done), 32'h2);
    chk("wr2 done mem_wr", 32'(mem_wr), 32'h0);
    req[1] = 1'b0; io_buffer_full = 1'b0;
    cyc(); settle();
    chk("wr2 ram 2000", 32'(peek(18'h02000)), 32'hEF);
    chk("wr2 ram 2001", 32'(peek(18'h02001)), 32'hBE);
    chk("wr2 ram 2002", 32'(peek(18'h02002)), 32'h5A);

    // Contention: both channels hold 1-byte reads
    cyc(); set_ch(0, 1'b0, 32'h100, 2'b00, 32'h0); set_ch(1, 1'b0, 32'h101, 2'b00, 32'h0);
    for (int t = 0; t < 3; t++) begin
      cyc(); settle();
      chk("arb grant", 32'(grant), 32'(exp_g[t]));
      cyc();
      cyc(); settle();
      chk("arb done", 32'(done), 32'(exp_g[t]));
      chk("arb rdata", rdata, (exp_g[t] == 2'b01) ? 32'h11 : 32'h22);
      if (t == 2) req = '0;
      cyc();
    end

    // IO back-pressure: 1-byte write to UART window, 3 stall cycles
    cyc(); set_ch(0, 1'b1, 32'h30000, 2'b00, 32'h41); io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("io stall mem_wr", 32'(mem_wr), 32'h0);
      chk("io stall mem_a", mem_a, 32'h30000);
    end
    cyc(); io_buffer_full = 1'b0; settle();
    chk("io write mem_wr", 32'(mem_wr), 32'h1);
    chk("io write dout", 32'(mem_dout), 32'h41);
    cyc(); settle();
    chk("io done", 32'(done), 32'h1);
    chk("io done mem_wr", 32'(mem_wr), 32'h0);
    req[0] = 1'b0;
    cyc(); settle();
    chk("io ram", 32'(peek(18'h30000)), 32'h41);

    // Reset during a 4-byte read at k=2
    cyc(); set_ch(0, 1'b0, 32'h100, 2'b10, 32'h0);
    cyc(); settle();
    chk("rstmid k0", mem_a, 32'h100);
    cyc(); settle();
    chk("rstmid k1", mem_a, 32'h101);
    cyc(); settle();
    chk("rstmid k2", mem_a, 32'h102);
    rst = 1'b1;
    cyc(); settle();
    chk("rstmid grant", 32'(grant), 32'h0);
    chk("rstmid done", 32'(done), 32'h0);
    chk("rstmid mem_wr", 32'(mem_wr), 32'h0);
    chk("rstmid mem_a", mem_a, 32'h0);
    chk("rstmid rdata", rdata, 32'h0);
    rst = 1'b0; req = '0;
    cyc(); settle();
    chk("rstmid idle grant", 32'(grant), 32'h0);

    // rdy low for 2 cycles mid-read (size code 11 = 4 bytes)
    cyc(); set_ch(1, 1'b0, 32'h100, 2'b11, 32'h0);
    cyc(); settle();
    chk("frz k0", mem_a, 32'h100);
    cyc(); settle();
    chk("frz k1", mem_a, 32'h101);
    cyc(); rdy = 1'b0; settle();
    chk("frz k2", mem_a, 32'h102);
    cyc(); settle();
    chk("frz hold", mem_a, 32'h102);
    chk("frz mem_wr", 32'(mem_wr), 32'h0);
    cyc(); rdy = 1'b1; settle();
    chk("frz hold2", mem_a, 32'h102);
    cyc(); settle();
    chk("frz k3", mem_a, 32'h103);
    cyc(); settle();
    chk("frz early done", 32'(done), 32'h0);
    cyc(); settle();
    chk("frz done", 32'(done), 32'h2);
    chk("frz rdata", rdata, 32'h44332211);
    req[1] = 1'b0;

    // 1-byte read at 0x1FFFF; upper rdata bytes must clear
    cyc(); set_ch(0, 1'b0, 32'h1FFFF, 2'b00, 32'h0);
    cyc(); settle();
    chk("rd1 mem_a", mem_a, 32'h1FFFF);
    cyc(); settle();
    chk("rd1 early done", 32'(done), 32'h0);
    cyc(); settle();
    chk("rd1 done", 32'(done), 32'h1);
    chk("rd1 rdata", rdata, 32'h000000A5);
    req[0] = 1'b0;

    // 2-byte read wrapping past 0xFFFFFFFF
    cyc(); set_ch(0, 1'b0, 32'hFFFFFFFF, 2'b01, 32'h0);
    cyc(); settle();
    chk("wrap a0", mem_a, 32'hFFFFFFFF);
    cyc(); settle();
    chk("wrap a1", mem_a, 32'h00000000);
    cyc();
    cyc(); settle();
    chk("wrap done", 32'(done), 32'h1);
    chk("wrap rdata", rdata, 32'h00008877);
    req[0] = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
